// File: rtl/psum_drain_stage.sv
// psum_drain_stage: serialises a vector of partial sums onto a one-word output channel
module psum_drain_stage #(
    parameter int PEROW   = 4,
    parameter int PSUMDWD = 32,
    parameter int AWD     = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               SS_rdy,
    output logic               SS_ack,
    input  logic [PSUMDWD-1:0] i_sum [PEROW],
    input  logic               i_psum_mode,
    input  logic [AWD-1:0]     i_base_addr,
    output logic               PO_rdy,
    input  logic               PO_ack,
    output logic [PSUMDWD-1:0] o_data,
    output logic [AWD-1:0]     o_addr,
    output logic               o_last
);
    localparam int IW = $clog2(PEROW);

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      cnt_q, cnt_d, last_idx, lo_idx, hi_idx;
    logic [PSUMDWD-1:0] sum_q [PEROW];
    logic [PSUMDWD-1:0] sum_d [PEROW];
    logic               mode_q, mode_d;
    logic [AWD-1:0]     base_q, base_d;
    logic               ss_xfer, po_xfer;

    assign ss_xfer = SS_rdy && SS_ack;
    assign po_xfer = PO_rdy && PO_ack;

    // state and datapath registers, cleared by the active-low synchronous reset
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            base_q  <= '0;
            for (int i = 0; i < PEROW; i++) sum_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            base_q  <= base_d;
            for (int i = 0; i < PEROW; i++) sum_q[i] <= sum_d[i];
        end
    end

    // next state: a new vector always wins, otherwise the last beat returns to idle
    always_comb begin
        state_d = ss_xfer ? SEND : (po_xfer && o_last) ? IDLE : state_q;
    end

    // capture the vector on accept and advance the beat counter on each non-final beat
    always_comb begin
        for (int i = 0; i < PEROW; i++) sum_d[i] = ss_xfer ? i_sum[i] : sum_q[i];
        mode_d = ss_xfer ? i_psum_mode : mode_q;
        base_d = ss_xfer ? i_base_addr : base_q;
        cnt_d  = ss_xfer ? '0 : (po_xfer && !o_last) ? cnt_q + IW'(1) : cnt_q;
    end

    // output decode from registered state; only SS_ack looks at PO_ack
    always_comb begin
        last_idx = mode_q ? IW'(PEROW - 1) : IW'(PEROW / 2 - 1);
        lo_idx   = cnt_q << 1;
        hi_idx   = lo_idx + IW'(1);
        PO_rdy   = (state_q == SEND);
        o_last   = PO_rdy && (cnt_q == last_idx);
        o_data   = mode_q ? sum_q[cnt_q]
                          : PSUMDWD'({sum_q[hi_idx][15:0], sum_q[lo_idx][15:0]});
        o_addr   = base_q + AWD'(cnt_q);
        SS_ack   = !PO_rdy || (PO_ack && o_last);
    end
endmodule

// File: tb/tb_psum_drain_stage.sv
// tb_psum_drain_stage: directed bench with a word-queue reference model for psum_drain_stage
module tb_psum_drain_stage;
    logic        clk = 1'b0;
    logic        i_rst;
    logic        SS_rdy;
    logic        SS_ack;
    logic [31:0] i_sum [4];
    logic        i_psum_mode;
    logic [7:0]  i_base_addr;
    logic        PO_rdy;
    logic        PO_ack;
    logic [31:0] o_data;
    logic [7:0]  o_addr;
    logic        o_last;

    typedef struct packed {
        logic [31:0] d;
        logic [7:0]  a;
        logic        l;
    } beat_t;

    beat_t q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    bit    live    = 0;
    bit    post_rst = 0;

    always #5 clk = ~clk;

    psum_drain_stage #(.PEROW(4), .PSUMDWD(32), .AWD(8)) dut (
        .i_clk(clk), .i_rst(i_rst), .SS_rdy(SS_rdy), .SS_ack(SS_ack), .i_sum(i_sum),
        .i_psum_mode(i_psum_mode), .i_base_addr(i_base_addr), .PO_rdy(PO_rdy),
        .PO_ack(PO_ack), .o_data(o_data), .o_addr(o_addr), .o_last(o_last)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: each accepted vector becomes a list of expected words
    always @(negedge clk) begin
        bit exp_ack;
        exp_ack = (q.size() == 0) || (PO_ack && q[0].l);
        if (live) begin
            chk("m_po_rdy", PO_rdy, q.size() != 0);
            chk("m_ss_ack", SS_ack, exp_ack);
            if (q.size() != 0) begin
                chk("m_data", o_data, q[0].d);
                chk("m_addr", o_addr, q[0].a);
                chk("m_last", o_last, q[0].l);
            end else chk("m_last_idle", o_last, 0);
            if (post_rst) begin
                chk("m_rst_data", o_data, 0);
                chk("m_rst_addr", o_addr, 0);
            end
        end
        post_rst = 0;
        if (!i_rst) begin
            q.delete();
            live = 1;
            post_rst = 1;
        end else begin
            if (q.size() != 0 && PO_ack) void'(q.pop_front());
            if (SS_rdy && exp_ack) begin
                if (i_psum_mode)
                    for (int k = 0; k < 4; k++)
                        q.push_back('{d: i_sum[k], a: i_base_addr + 8'(k), l: k == 3});
                else
                    for (int k = 0; k < 2; k++)
                        q.push_back('{d: {i_sum[2*k+1][15:0], i_sum[2*k][15:0]},
                                      a: i_base_addr + 8'(k), l: k == 1});
            end
        end
    end

    task automatic send(input logic m, input logic [7:0] b,
                        input logic [31:0] s0, s1, s2, s3);
        bit ok = 0;
        @(posedge clk); #1;
        SS_rdy = 1; i_psum_mode = m; i_base_addr = b;
        i_sum[0] = s0; i_sum[1] = s1; i_sum[2] = s2; i_sum[3] = s3;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (SS_ack) begin ok = 1; break; end
        end
        chk("ss_accept", 32'(ok), 1);
        @(posedge clk); #1;
        SS_rdy = 0; i_psum_mode = 1'($urandom); i_base_addr = 8'($urandom);
        for (int i = 0; i < 4; i++) i_sum[i] = $urandom;
    endtask

    task automatic beat(input logic [31:0] d, input logic [7:0] a, input logic l);
        @(negedge clk);
        chk("lit_data", o_data, d);
        chk("lit_addr", 32'(o_addr), 32'(a));
        chk("lit_last", 32'(o_last), 32'(l));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        i_rst = 0; SS_rdy = 0; PO_ack = 1; i_psum_mode = 0; i_base_addr = 0;
        for (int i = 0; i < 4; i++) i_sum[i] = 0;
        repeat (2) @(negedge clk);
        chk("rst_po_rdy", 32'(PO_rdy), 0);
        chk("rst_data", o_data, 0);
        chk("rst_addr", 32'(o_addr), 0);
        chk("rst_ss_ack", 32'(SS_ack), 1);
        @(posedge clk); #1 i_rst = 1;

        send(1, 8'h10, 32'h1, 32'hfffffffe, 32'h7fffffff, 32'h80000000);
        beat(32'h00000001, 8'h10, 0);
        beat(32'hfffffffe, 8'h11, 0);
        beat(32'h7fffffff, 8'h12, 0);
        beat(32'h80000000, 8'h13, 1);

        send(0, 8'h20, 32'h1234, 32'h8000, 32'h7fff, 32'h0001);
        beat(32'h80001234, 8'h20, 0);
        beat(32'h00017fff, 8'h21, 1);
        repeat (2) @(posedge clk);

        send(1, 8'h30, 32'ha0, 32'ha1, 32'ha2, 32'ha3);
        beat(32'ha0, 8'h30, 0);
        @(posedge clk); #1 PO_ack = 0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_data", o_data, 32'ha1);
            chk("bp_addr", 32'(o_addr), 32'h31);
            chk("bp_ss_ack", 32'(SS_ack), 0);
        end
        @(posedge clk); #1 PO_ack = 1;
        beat(32'ha1, 8'h31, 0);
        beat(32'ha2, 8'h32, 0);
        beat(32'ha3, 8'h33, 1);

        send(1, 8'h40, 32'hb0, 32'hb1, 32'hb2, 32'hb3);
        fork
            send(0, 8'h50, 32'haaaa, 32'hbbbb, 32'hcccc, 32'hdddd);
            begin
                beat(32'hb0, 8'h40, 0);
                beat(32'hb1, 8'h41, 0);
                beat(32'hb2, 8'h42, 0);
                beat(32'hb3, 8'h43, 1);
                beat(32'hbbbbaaaa, 8'h50, 0);
                beat(32'hddddcccc, 8'h51, 1);
            end
        join

        send(1, 8'hfe, 32'h5, 32'h6, 32'h7, 32'h8);
        beat(32'h5, 8'hfe, 0);
        beat(32'h6, 8'hff, 0);
        beat(32'h7, 8'h00, 0);
        beat(32'h8, 8'h01, 1);

        send(1, 8'hfe, 32'h9, 32'ha, 32'hb, 32'hc);
        beat(32'h9, 8'hfe, 0);
        beat(32'ha, 8'hff, 0);
        @(posedge clk); #1 i_rst = 0;
        @(posedge clk); #1 i_rst = 1;
        @(negedge clk);
        chk("mrst_data", o_data, 0);
        chk("mrst_addr", 32'(o_addr), 0);
        chk("mrst_ss_ack", 32'(SS_ack), 1);
        repeat (4) begin
            chk("mrst_po_rdy", 32'(PO_rdy), 0);
            @(negedge clk);
        end

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
